// File: rtl/seg_msg_player.sv
// Seven-segment message player: buffers up to eight 4-bit codes and, while play is
// held, cycles through them one per dwell period followed by one blank period.
module seg_msg_player #(
   parameter int DWELL_LOG2 = 10
) (
   input  logic [7:0] io_in,
   output logic [7:0] io_out
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SHOW = 2'd1,
      GAP  = 2'd2
   } state_t;

   logic       clk;
   logic       rst;
   logic       wr;
   logic       play;
   logic [3:0] data;

   assign clk  = io_in[0];
   assign rst  = io_in[1];
   assign wr   = io_in[2];
   assign play = io_in[3];
   assign data = io_in[7:4];

   state_t                state;
   state_t                state_nxt;
   logic [DWELL_LOG2-1:0] timer;
   logic [2:0]            idx;
   logic [3:0]            count;
   logic [3:0]            count_nxt;
   logic [3:0]            msg_mem [8];
   logic                  wr_p0;
   logic                  wr_evt;
   logic                  accept;
   logic                  timer_end;
   logic                  last_char;

   // Segment pattern for a code, active-low {DP,G,F,E,D,C,B,A}; code F is blank.
   function automatic logic [7:0] enc(input logic [3:0] code);
      logic [7:0] seg;
      case (code)
         4'h0:    seg = 8'hC0;
         4'h1:    seg = 8'hF9;
         4'h2:    seg = 8'hA4;
         4'h3:    seg = 8'hB0;
         4'h4:    seg = 8'h99;
         4'h5:    seg = 8'h92;
         4'h6:    seg = 8'h82;
         4'h7:    seg = 8'hF8;
         4'h8:    seg = 8'h80;
         4'h9:    seg = 8'h90;
         4'hA:    seg = 8'h88;
         4'hB:    seg = 8'h83;
         4'hC:    seg = 8'hC6;
         4'hD:    seg = 8'hA1;
         4'hE:    seg = 8'h86;
         default: seg = 8'hFF;
      endcase
      return seg;
   endfunction

   assign wr_evt    = wr & ~wr_p0;
   assign accept    = wr_evt && (state == IDLE) && (count < 4'd8);
   assign count_nxt = count + {3'b000, accept};
   assign timer_end = (timer == {DWELL_LOG2{1'b1}});
   assign last_char = ({1'b0, idx} == (count - 4'd1));

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // A write accepted on the same edge already counts toward starting playback.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (play && (count_nxt != 4'd0)) state_nxt = SHOW;
         SHOW: begin
            if (!play)                       state_nxt = IDLE;
            else if (timer_end && last_char) state_nxt = GAP;
         end
         GAP: begin
            if (!play)          state_nxt = IDLE;
            else if (timer_end) state_nxt = SHOW;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Any state change restarts the dwell and returns to the first character.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_p0 <= 1'b0;
         count <= 4'd0;
         idx   <= 3'd0;
         timer <= '0;
      end else begin
         wr_p0 <= wr;
         if (accept) count <= count_nxt;
         if ((state_nxt != state) || (state == IDLE)) begin
            timer <= '0;
            idx   <= 3'd0;
         end else if (timer_end) begin
            timer <= '0;
            idx   <= idx + 3'd1;
         end else begin
            timer <= timer + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept && !rst) msg_mem[count[2:0]] <= data;
   end

   always_comb begin
      io_out = 8'hFF;
      if (state == SHOW) io_out = enc(msg_mem[idx]);
   end

endmodule

// File: doc/seg_msg_player.md
SEG_MSG_PLAYER -- requirements
Module: seg_msg_player

Interface
REQ-001 Parameter DWELL_LOG2, default 10, SHALL set cycles per displayed character as DWELL = 2^DWELL_LOG2; legal range 1..20.
REQ-002 io_in[0]  input  1  clock; all state updates SHALL occur on its rising edge only.
REQ-003 io_in[1]  input  1  reset; synchronous, active-high.
REQ-004 io_in[2]  input  1  wr: load strobe, rising-edge sensitive.
REQ-005 io_in[3]  input  1  play: level; 1 = run message, 0 = stop.
REQ-006 io_in[7:4]  input  4  data: character code written on a wr rising edge.
REQ-007 io_out[7:0]  output  8  segment drive, common anode, active-low, bit order {DP,G,F,E,D,C,B,A}.

Function
REQ-008 Buffer SHALL hold 8 entries x 4 bits, plus a 4-bit count (0..8); entries are written in order at index = count.
REQ-009 wr edge detect SHALL use a registered copy of io_in[2]; a write event is io_in[2]=1 while the registered copy is 0; holding wr high SHALL produce exactly one write.
REQ-010 On a write event in state IDLE with count<8: data SHALL be stored at buf[count] and count SHALL increment at the same edge.
REQ-011 Write events with count==8, or in state SHOW or GAP, SHALL be ignored with no change to buffer or count.
REQ-012 States SHALL be IDLE, SHOW, GAP; a timer of DWELL_LOG2 bits and a 3-bit index idx SHALL be kept.
REQ-013 IDLE -> SHOW when play=1 and count>0, counting the write accepted at the same edge; idx <= 0, timer <= 0.
REQ-014 In SHOW the timer SHALL increment each cycle; at timer==DWELL-1: if idx==count-1 go to GAP with timer <= 0, else idx <= idx+1 with timer <= 0.
REQ-015 In GAP the timer SHALL increment each cycle; at timer==DWELL-1 go to SHOW with idx <= 0 and timer <= 0, so the message repeats.
REQ-016 In any state, play=0 at an edge SHALL force IDLE at that edge; buffer and count are retained.
REQ-017 play=1 with count==0 SHALL keep IDLE.
REQ-018 io_out SHALL be a combinational decode of registered state/idx/buffer: IDLE and GAP -> 8'hFF; SHOW -> enc(buf[idx]).
REQ-019 Encoding enc(code), DP always off:
  0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90,
  A 88 (A), B 83 (b), C C6 (C), D A1 (d), E 86 (E), F FF (blank).
REQ-020 Timer wrap SHALL follow REQ-014/REQ-015 only; no free-running overflow SHALL be visible on io_out.
REQ-021 No combinational path SHALL exist from io_in[7:2] to io_out.

Reset
REQ-022 With io_in[1]=1 at an edge: state <= IDLE, count <= 0, idx <= 0, timer <= 0, wr edge register <= 0; buffer contents need not be cleared.
REQ-023 Reset SHALL take priority over write events and play in the same cycle, including mid-SHOW or mid-GAP.
REQ-024 After reset, io_out SHALL be 8'hFF until a SHOW state is entered.

Verification (DWELL_LOG2=2, DWELL=4)
REQ-025 Reset held 2 cycles, play=0 -> io_out=FF; play=1 with no writes -> io_out stays FF.
REQ-026 With play=0, write codes 1,2,3; then play=1 -> io_out F9 x4 cycles, A4 x4, B0 x4, FF x4, then F9 again.
REQ-027 Write 9 codes 0..8 with play=0, then play=1 -> C0,F9,A4,B0,99,92,82,F8 at 4 cycles each, then FF x4; code 8 (80) never appears.
REQ-028 wr held high 10 cycles with data=E -> count=1 only; play=1 -> 86 x4 then FF x4, repeating.
REQ-029 play dropped in the 2nd cycle of showing A4 -> io_out=FF from that edge; writes are accepted again; play=1 restarts at idx 0 (F9).
REQ-030 Reset asserted mid-SHOW while play stays 1 -> io_out=FF and count=0; a write of code 0 in the following cycles -> C0 shown for 4 cycles after the next edge.
